// File: rtl/aes_pkg.sv
// Shared AES datapath types plus the ShiftRows row-offset helpers used by the
// stream stage and its permutation network.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  localparam int AES_ROWS = 4;

  function automatic bit nb_is_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael row offsets: 256-bit blocks use 0,1,3,4 instead of 0,1,2,3.
  function automatic int shift_amt(input int nb, input int row);
    if (nb == 8) begin
      return (row >= 2) ? row + 1 : row;
    end
    return row;
  endfunction

endpackage

// File: rtl/aes_shiftrow_perm.sv
// Combinational (Inv)ShiftRows byte permutation, zero latency, no flow control.
// Inverse network exists only with AES_SHIFTROW_INV_EN; otherwise dec is ignored.
module aes_shiftrow_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              dec,
  input  logic [32*NB-1:0]  data_in,
  output logic [32*NB-1:0]  data_out
);

  byte_t [NB-1:0][AES_ROWS-1:0] in_b;
  byte_t [NB-1:0][AES_ROWS-1:0] fwd_b;

  assign in_b = data_in;

  always_comb begin
    fwd_b = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < AES_ROWS; r++) begin
        fwd_b[c][r] = in_b[(c + shift_amt(NB, r)) % NB][r];
      end
    end
  end

`ifdef AES_SHIFTROW_INV_EN
  byte_t [NB-1:0][AES_ROWS-1:0] inv_b;

  // Offsets never exceed NB, so adding NB keeps the modulus operand positive.
  always_comb begin
    inv_b = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < AES_ROWS; r++) begin
        inv_b[c][r] = in_b[(c - shift_amt(NB, r) + NB) % NB][r];
      end
    end
  end

  assign data_out = dec ? inv_b : fwd_b;
`else
  logic dec_unused;

  assign dec_unused = dec;
  assign data_out   = fwd_b;
`endif

endmodule

// File: rtl/aes_shiftrow_stream.sv
// Handshaked ShiftRows/InvShiftRows stage (AES_SHIFTROW_INV_EN enables inverse), 1-cycle latency.
// Registered-ready skid buffer absorbs one block of backpressure; in_ready never depends on out_ready.
module aes_shiftrow_stream
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_dec,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam bit NB_OK = nb_is_legal(NB);

  generate
    if (!NB_OK) begin : g_nb_chk
      $error("aes_shiftrow_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  typedef struct packed {
    logic [32*NB-1:0] dat;
    logic [TAG_W-1:0] tag;
  } blk_t;

  logic [32*NB-1:0] perm_dat;
  blk_t             in_blk;
  blk_t             out_q, out_d;
  blk_t             skid_q, skid_d;
  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_acc;
  logic             out_xfer;

  aes_shiftrow_perm #(
    .NB (NB)
  ) u_perm (
    .dec      (in_dec),
    .data_in  (in_data),
    .data_out (perm_dat)
  );

  assign in_blk   = '{dat: perm_dat, tag: in_tag};
  assign in_acc   = in_valid & ~skid_vld_q;
  assign out_xfer = out_vld_q & out_ready;

  // A filled skid implies in_ready is low, so a drain never competes with an accept for it.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_acc) begin
        out_d = in_blk;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (!out_vld_q) begin
      if (in_acc) begin
        out_d     = in_blk;
        out_vld_d = 1'b1;
      end
    end else if (in_acc) begin
      skid_d     = in_blk;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_q.dat;
  assign out_tag   = out_q.tag;
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_aes_shiftrow_stream.sv
// Directed bench for aes_shiftrow_stream: NB=4 with a 4-bit counter and NB=8,
// expected blocks hand-computed from the ShiftRows definition.
module tb_aes_shiftrow_stream;

  localparam logic [127:0] A4   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] FWD4 = 128'h0B06010C_07020D08_030E0904_0F0A0500;
  localparam logic [127:0] DF4  = 128'h070E050C_030A0108_0F060D04_0B020900;
  localparam logic [127:0] INV4 = 128'h0306090C_0F020508_0B0E0104_070A0D00;
  localparam logic [127:0] ROW4 = 128'h33221100_33221100_33221100_33221100;

`ifdef AES_SHIFTROW_INV_EN
  localparam logic [127:0] EXP_FB    = A4;
  localparam logic [127:0] EXP_A_DEC = INV4;
  localparam logic [31:0]  EXP_B_DEC = 32'h13161D00;
`else
  localparam logic [127:0] EXP_FB    = DF4;
  localparam logic [127:0] EXP_A_DEC = FWD4;
  localparam logic [31:0]  EXP_B_DEC = 32'h130E0500;
`endif

  logic         CLK;
  logic         RST_N;

  logic         a_in_valid, a_in_ready, a_in_dec, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_out_data;
  logic [3:0]   a_in_tag, a_out_tag, a_blk_cnt;

  logic         b_in_valid, b_in_ready, b_in_dec, b_out_valid, b_out_ready;
  logic [255:0] b_in_data, b_out_data, b8;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [15:0]  b_blk_cnt;

  int n_chk;
  int n_bad;

  aes_shiftrow_stream #(.NB(4), .TAG_W(4), .CNT_W(4)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_dec(a_in_dec), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .blk_cnt(a_blk_cnt)
  );

  aes_shiftrow_stream #(.NB(8), .TAG_W(4), .CNT_W(16)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_dec(b_in_dec), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .blk_cnt(b_blk_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_drive(input logic vld, input logic [127:0] dat, input logic dec,
                         input logic [3:0] tag, input logic rdy);
    a_in_valid  = vld;
    a_in_data   = dat;
    a_in_dec    = dec;
    a_in_tag    = tag;
    a_out_ready = rdy;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    RST_N = 1'b0;
    a_drive(1'b0, '0, 1'b0, 4'd0, 1'b0);
    b_in_valid = 1'b0; b_in_data = '0; b_in_dec = 1'b0; b_in_tag = '0; b_out_ready = 1'b0;
    for (int i = 0; i < 32; i++) b8[8*i +: 8] = 8'(i);

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready",  a_in_ready, 1);
    chk("rst_blk_cnt",   a_blk_cnt, 0);
    chk("rst_out_data",  a_out_data, 0);
    chk("rst_out_tag",   a_out_tag, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    RST_N = 1'b1;

    // NB=4 forward, 1-cycle latency
    a_drive(1'b1, A4, 1'b0, 4'd1, 1'b1);
    @(negedge CLK);
    chk("fwd_valid", a_out_valid, 1);
    chk("fwd_data",  a_out_data, FWD4);
    chk("fwd_tag",   a_out_tag, 4'd1);
    chk("fwd_cnt_pre", a_blk_cnt, 0);
    a_drive(1'b1, FWD4, 1'b1, 4'd2, 1'b1);
    @(negedge CLK);
    chk("fwd_cnt", a_blk_cnt, 1);
    chk("fb_data", a_out_data, EXP_FB);
    chk("fb_tag",  a_out_tag, 4'd2);
    a_drive(1'b1, A4, 1'b1, 4'd3, 1'b1);
    @(negedge CLK);
    chk("dec_data", a_out_data, EXP_A_DEC);
    a_drive(1'b0, '0, 1'b0, 4'd0, 1'b1);
    @(negedge CLK);
    chk("idle_valid", a_out_valid, 0);
    chk("idle_cnt",   a_blk_cnt, 3);

    // NB=8 forward and dec on the wide instance
    b_in_valid = 1'b1; b_in_data = b8; b_in_dec = 1'b0; b_in_tag = 4'd3; b_out_ready = 1'b1;
    @(negedge CLK);
    chk("nb8_col0", b_out_data[31:0], 32'h130E0500);
    chk("nb8_col7", b_out_data[255:224], 32'h0F0A011C);
    chk("nb8_tag",  b_out_tag, 4'd3);
    b_in_dec = 1'b1;
    @(negedge CLK);
    chk("nb8_dec_col0", b_out_data[31:0], EXP_B_DEC);
    b_in_valid = 1'b0;
    @(negedge CLK);
    chk("nb8_cnt",   b_blk_cnt, 2);
    chk("nb8_valid", b_out_valid, 0);

    // Three-block stream with two stalled cycles after the first
    a_drive(1'b1, A4, 1'b0, 4'd1, 1'b1);
    @(negedge CLK);
    chk("s1_tag",  a_out_tag, 4'd1);
    chk("s1_data", a_out_data, FWD4);
    a_drive(1'b1, FWD4, 1'b0, 4'd2, 1'b0);
    @(negedge CLK);
    chk("s2_in_ready", a_in_ready, 0);
    chk("s2_hold_tag", a_out_tag, 4'd1);
    a_drive(1'b1, ROW4, 1'b1, 4'd3, 1'b0);
    @(negedge CLK);
    chk("s3_in_ready", a_in_ready, 0);
    chk("s3_hold_data", a_out_data, FWD4);
    a_out_ready = 1'b1;
    @(negedge CLK);
    chk("s4_tag",  a_out_tag, 4'd2);
    chk("s4_data", a_out_data, DF4);
    chk("s4_in_ready", a_in_ready, 1);
    @(negedge CLK);
    chk("s5_tag",  a_out_tag, 4'd3);
    chk("s5_data", a_out_data, ROW4);
    a_in_valid = 1'b0;
    @(negedge CLK);
    chk("s6_valid", a_out_valid, 0);
    chk("s6_cnt",   a_blk_cnt, 6);

    // Backpressure hold for 10 cycles
    a_drive(1'b1, A4, 1'b0, 4'd5, 1'b0);
    @(negedge CLK);
    a_in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", a_out_valid, 1);
      chk("hold_data",  a_out_data, FWD4);
      chk("hold_tag",   a_out_tag, 4'd5);
      chk("hold_cnt",   a_blk_cnt, 6);
      @(negedge CLK);
    end
    a_out_ready = 1'b1;
    @(negedge CLK);
    chk("hold_rel_cnt",   a_blk_cnt, 7);
    chk("hold_rel_valid", a_out_valid, 0);

    // Async reset with the skid full
    a_drive(1'b1, A4, 1'b0, 4'd6, 1'b0);
    @(negedge CLK);
    a_drive(1'b1, ROW4, 1'b0, 4'd7, 1'b0);
    @(negedge CLK);
    chk("pre_rst_in_ready", a_in_ready, 0);
    #2;
    RST_N = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("arst_out_valid", a_out_valid, 0);
    chk("arst_in_ready",  a_in_ready, 1);
    chk("arst_cnt",       a_blk_cnt, 0);
    chk("arst_data",      a_out_data, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    a_drive(1'b1, A4, 1'b0, 4'd9, 1'b1);
    @(negedge CLK);
    chk("post_rst_valid", a_out_valid, 1);
    chk("post_rst_data",  a_out_data, FWD4);
    chk("post_rst_tag",   a_out_tag, 4'd9);
    a_in_valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_cnt", a_blk_cnt, 1);

    // 4-bit counter wrap: 16 more transfers make 17 since reset
    a_drive(1'b1, ROW4, 1'b0, 4'hA, 1'b1);
    repeat (16) @(negedge CLK);
    chk("wrap_zero", a_blk_cnt, 0);
    a_in_valid = 1'b0;
    @(negedge CLK);
    chk("wrap_one",   a_blk_cnt, 1);
    chk("wrap_valid", a_out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
